dualram_burst_reader: RTL

Read-side engine for the 8x4 dual-port RAM. It holds its own 8x4 array, which the existing write path loads through a single write port. Two requesters, port 0 and port 1, issue burst read requests; a round-robin arbiter grants one burst at a time. Each granted burst streams out over a valid/ready interface with wrap-around addressing, so a consumer can read back what the write path stored.

---
 rtl/dualram_pkg.sv | 26 ++
 rtl/dualram_rr_arb.sv | 41 ++++
 rtl/dualram_burst_reader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dualram_pkg.sv
// ============================================================================
// Module   : dualram_pkg
// Purpose  : Shared sizes and types for the 8x4 dual-port RAM burst reader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dualram_pkg;

    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;
    localparam int LW    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [LW-1:0] len_t;

endpackage

`default_nettype wire

// File: rtl/dualram_rr_arb.sv
// ============================================================================
// Module   : dualram_rr_arb
// Purpose  : Two-requester round-robin arbiter with a last-served pointer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dualram_rr_arb
    import dualram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // Index of the port served most recently; starts at 1 so port 0 wins first.
    logic r_last;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (update && (gnt != 2'b00)) begin
            r_last <= gnt[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dualram_burst_reader.sv
// ============================================================================
// Module   : dualram_burst_reader
// Purpose  : 8x4 RAM with one write port and a two-port arbitrated burst reader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dualram_burst_reader
    import dualram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req0,
    input  logic [AW-1:0] rd_addr0,
    input  logic [2:0]    rd_len0,
    input  logic          rd_req1,
    input  logic [AW-1:0] rd_addr1,
    input  logic [2:0]    rd_len1,
    output logic          rd_ack0,
    output logic          rd_ack1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_port,
    output logic          out_last,
    output logic          busy
);

    data_t     r_mem [DEPTH];
    rd_state_t r_state, w_state_nxt;
    addr_t     r_addr, w_addr_nxt;
    len_t      r_beats, w_beats_nxt;
    data_t     r_data, w_data_nxt;
    logic      r_valid, w_valid_nxt;
    logic      r_port, w_port_nxt;
    logic      r_last, w_last_nxt;
    logic      r_busy, w_busy_nxt;
    logic [1:0] r_ack, w_ack_nxt;

    logic [1:0] w_gnt;
    logic       w_arb_update;
    logic       w_sel;
    addr_t      w_req_addr, w_step_addr;
    len_t       w_req_len;
    data_t      w_req_data, w_step_data;

    dualram_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({rd_req1, rd_req0}),
        .update (w_arb_update),
        .gnt    (w_gnt)
    );

    // Memory is never cleared, so writes land even while rst is high.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign w_sel       = w_gnt[1];
    assign w_req_addr  = w_sel ? rd_addr1 : rd_addr0;
    assign w_req_len   = w_sel ? rd_len1  : rd_len0;
    assign w_step_addr = r_addr + addr_t'(1);

    // Write-first bypass for whichever address is being loaded this edge.
    assign w_req_data  = (wr_en && (wr_addr == w_req_addr))  ? wr_data : r_mem[w_req_addr];
    assign w_step_data = (wr_en && (wr_addr == w_step_addr)) ? wr_data : r_mem[w_step_addr];

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_beats_nxt  = r_beats;
        w_data_nxt   = r_data;
        w_valid_nxt  = r_valid;
        w_port_nxt   = r_port;
        w_last_nxt   = r_last;
        w_busy_nxt   = r_busy;
        w_ack_nxt    = 2'b00;
        w_arb_update = 1'b0;

        case (r_state)
            IDLE: begin
                if (rd_req0 || rd_req1) begin
                    w_arb_update = 1'b1;
                    w_state_nxt  = BURST;
                    w_ack_nxt    = w_gnt;
                    w_addr_nxt   = w_req_addr;
                    w_beats_nxt  = w_req_len;
                    w_port_nxt   = w_sel;
                    w_data_nxt   = w_req_data;
                    w_valid_nxt  = 1'b1;
                    w_last_nxt   = (w_req_len == len_t'(0));
                    w_busy_nxt   = 1'b1;
                end
            end
            BURST: begin
                if (r_valid && out_ready) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_addr_nxt  = w_step_addr;
                        w_beats_nxt = r_beats - len_t'(1);
                        w_data_nxt  = w_step_data;
                        w_last_nxt  = (r_beats == len_t'(1));
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_beats <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_port  <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_ack   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_beats <= w_beats_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_port  <= w_port_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    assign rd_ack0   = r_ack[0];
    assign rd_ack1   = r_ack[1];
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_port  = r_port;
    assign out_last  = r_last;
    assign busy      = r_busy;

endmodule

`default_nettype wire
